// File: rtl/shared_dmem_arbiter.sv
// Shared single-port data memory with round-robin arbitration across NCORES cores.
// One access is in flight at a time: IDLE picks a core, ACCESS runs LAT cycles, RESP pulses ACK.
module shared_dmem_arbiter #(
  parameter int NCORES = 2,
  parameter int DEPTH  = 256,
  parameter int LAT    = 1
) (
  input  logic                   clk,
  input  logic                   RST,
  input  logic [NCORES-1:0]      REQ,
  input  logic [NCORES-1:0]      WE,
  input  logic [16*NCORES-1:0]   ADDR,
  input  logic [16*NCORES-1:0]   WDATA,
  output logic [16*NCORES-1:0]   RDATA,
  output logic [NCORES-1:0]      ACK,
  output logic                   BUSY,
  output logic [NCORES-1:0]      GNT
);
  localparam int AW = $clog2(DEPTH);
  localparam int SW = (NCORES > 1) ? $clog2(NCORES) : 1;
  localparam int CW = (LAT > 1) ? $clog2(LAT) : 1;

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_e;

  state_e                   state_q, state_d;
  logic [SW-1:0]            sel_q, sel_d, last_q, last_d, pick;
  logic                     found;
  logic                     we_q, we_d;
  logic [AW-1:0]            addr_q, addr_d;
  logic [15:0]              wdata_q, wdata_d;
  logic [CW-1:0]            cnt_q, cnt_d;
  logic [NCORES-1:0]        ack_q, ack_d, gnt_q, gnt_d;
  logic [NCORES-1:0][15:0]  rdata_q, rdata_d;
  logic [NCORES-1:0][15:0]  addr_v, wdata_v;
  logic [15:0]              mem [DEPTH];
  logic                     mem_we;
  logic                     unused_hi;
  int                       idx;

  assign addr_v    = ADDR;
  assign wdata_v   = WDATA;
  assign unused_hi = ^ADDR;

  // Scan last+1, last+2, ... so the most recently served core has lowest priority.
  always_comb begin
    found = 1'b0;
    pick  = last_q;
    idx   = 0;
    for (int k = 1; k <= NCORES; k++) begin
      idx = (int'(last_q) + k) % NCORES;
      if (!found && REQ[SW'(idx)]) begin
        found = 1'b1;
        pick  = SW'(idx);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    last_d  = last_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    cnt_d   = cnt_q;
    ack_d   = '0;
    gnt_d   = gnt_q;
    rdata_d = rdata_q;
    mem_we  = 1'b0;
    case (state_q)
      IDLE: if (found) begin
        sel_d       = pick;
        we_d        = WE[pick];
        addr_d      = addr_v[pick][AW-1:0];
        wdata_d     = wdata_v[pick];
        gnt_d       = '0;
        gnt_d[pick] = 1'b1;
        cnt_d       = CW'(LAT - 1);
        state_d     = ACCESS;
      end
      ACCESS: if (cnt_q != '0) begin
        cnt_d = cnt_q - 1'b1;
      end else begin
        if (we_q) mem_we = 1'b1;
        else      rdata_d[sel_q] = mem[addr_q];
        ack_d[sel_q] = 1'b1;
        last_d       = sel_q;
        state_d      = RESP;
      end
      RESP: begin
        gnt_d   = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (RST) begin
      state_q <= IDLE;
      sel_q   <= '0;
      last_q  <= SW'(NCORES - 1);
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      cnt_q   <= '0;
      ack_q   <= '0;
      gnt_q   <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      last_q  <= last_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      cnt_q   <= cnt_d;
      ack_q   <= ack_d;
      gnt_q   <= gnt_d;
      rdata_q <= rdata_d;
    end
  end

  // RAM contents survive reset; a reset on the commit edge suppresses the write.
  always_ff @(posedge clk) begin
    if (mem_we && !RST) mem[addr_q] <= wdata_q;
  end

  assign BUSY  = (state_q != IDLE);
  assign ACK   = ack_q;
  assign GNT   = gnt_q;
  assign RDATA = rdata_q;
endmodule

// File: tb/tb_shared_dmem_arbiter.sv
// Scoreboard bench: LAT=1 and LAT=3 instances share stimulus; a reference model predicts
// service order, ACK cycle and RDATA, and a negedge monitor compares on every ACK.
module tb_shared_dmem_arbiter;
  localparam int NC    = 2;
  localparam int DEPTH = 256;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                RST;
  logic [NC-1:0]       REQ, WE;
  logic [16*NC-1:0]    ADDR, WDATA;
  logic [16*NC-1:0]    rd1, rd3;
  logic [NC-1:0]       ack1, ack3, gnt1, gnt3;
  logic                busy1, busy3;

  shared_dmem_arbiter #(.NCORES(NC), .DEPTH(DEPTH), .LAT(1)) u_l1 (
    .clk(clk), .RST(RST), .REQ(REQ), .WE(WE), .ADDR(ADDR), .WDATA(WDATA),
    .RDATA(rd1), .ACK(ack1), .BUSY(busy1), .GNT(gnt1));
  shared_dmem_arbiter #(.NCORES(NC), .DEPTH(DEPTH), .LAT(3)) u_l3 (
    .clk(clk), .RST(RST), .REQ(REQ), .WE(WE), .ADDR(ADDR), .WDATA(WDATA),
    .RDATA(rd3), .ACK(ack3), .BUSY(busy3), .GNT(gnt3));

  int lat = 1;
  logic [NC-1:0][15:0] rd_m;
  logic [NC-1:0]       ack_m, gnt_m;
  logic                busy_m;
  always_comb begin
    rd_m   = (lat == 3) ? rd3   : rd1;
    ack_m  = (lat == 3) ? ack3  : ack1;
    gnt_m  = (lat == 3) ? gnt3  : gnt1;
    busy_m = (lat == 3) ? busy3 : busy1;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errs = 0, checks = 0;
  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d, LAT=%0d)", nm, act, exp, cyc, lat);
    end
  endtask

  // Reference model: flat memory array, per-core last read value, round-robin pointer.
  typedef struct {
    int                  core;
    int                  cyc;
    logic [NC-1:0][15:0] rd;
  } exp_t;
  exp_t                q[$];
  logic [15:0]         mdl_mem [DEPTH];
  logic [NC-1:0][15:0] mdl_rd;
  int                  mdl_last;

  function automatic void model_push(int c, bit w, logic [15:0] a, logic [15:0] d, int at);
    exp_t e;
    int   ia = int'(a) % DEPTH;
    if (w) mdl_mem[ia] = d;
    else   mdl_rd[c] = mdl_mem[ia];
    mdl_last = c;
    e.core = c;
    e.cyc  = at;
    e.rd   = mdl_rd;
    q.push_back(e);
  endfunction

  exp_t          me;
  logic [NC-1:0] moh;
  always @(negedge clk) begin
    if (|ack_m) begin
      if (q.size() == 0) chk("unexpected_ack", ack_m, '0);
      else begin
        me = q.pop_front();
        moh = '0;
        moh[me.core] = 1'b1;
        chk("ack_core", ack_m, moh);
        chk("ack_cycle", cyc, me.cyc);
        chk("gnt_at_ack", gnt_m, moh);
        chk("busy_at_ack", busy_m, 1'b1);
        chk("rdata", rd_m, me.rd);
      end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    RST = 1'b1;
    REQ = '0;
    repeat (2) @(negedge clk);
    RST = 1'b0;
    mdl_last = NC - 1;
    mdl_rd   = '0;
    q.delete();
  endtask

  // One batch of simultaneous requests; each core holds REQ until its own ACK.
  task automatic round(logic [NC-1:0] mask, logic [NC-1:0] w,
                       logic [NC-1:0][15:0] a, logic [NC-1:0][15:0] d);
    int n, at, start, c;
    logic [NC-1:0] pend;
    @(negedge clk);
    n = cyc;
    for (int i = 0; i < NC; i++) begin
      WE[i]            = w[i];
      ADDR[16*i +: 16] = a[i];
      WDATA[16*i +: 16]= d[i];
    end
    REQ   = mask;
    at    = n + 1 + lat;
    start = mdl_last;
    for (int k = 1; k <= NC; k++) begin
      c = (start + k) % NC;
      if (mask[c]) begin
        model_push(c, w[c], a[c], d[c], at);
        at += lat + 2;
      end
    end
    pend = mask;
    for (int t = 0; t < 60 && pend != '0; t++) begin
      @(negedge clk);
      pend &= ~ack_m;
      REQ  &= ~ack_m;
    end
    chk("round_complete", pend, '0);
    if (pend != '0) begin
      REQ = '0;
      q.delete();
    end
  endtask

  task automatic one(int c, bit w, logic [15:0] a, logic [15:0] d);
    logic [NC-1:0]       m  = '0, wv = '0;
    logic [NC-1:0][15:0] av = '0, dv = '0;
    m[c]  = 1'b1;
    wv[c] = w;
    av[c] = a;
    dv[c] = d;
    round(m, wv, av, dv);
  endtask

  task automatic suite();
    logic [NC-1:0][15:0] av, dv;
    logic [NC-1:0]       m, wv;
    do_reset();
    @(negedge clk);
    chk("rst_ack", ack_m, '0);
    chk("rst_gnt", gnt_m, '0);
    chk("rst_busy", busy_m, 1'b0);
    chk("rst_rdata", rd_m, '0);
    repeat (2) @(negedge clk);
    chk("idle_busy", busy_m, 1'b0);

    one(0, 1'b1, 16'h0010, 16'hBEEF);
    one(0, 1'b0, 16'h0010, 16'h0000);

    one(0, 1'b1, 16'h0001, 16'h1111);
    one(1, 1'b1, 16'h0002, 16'h2222);
    do_reset();
    av[0] = 16'h0001; av[1] = 16'h0002; dv = '0;
    for (int r = 0; r < 3; r++) round(2'b11, 2'b00, av, dv);

    one(1, 1'b1, 16'h0105, 16'h1234);
    one(1, 1'b0, 16'h0005, 16'h0000);

    for (int a = 0; a < 16; a++) one(a % NC, 1'b1, 16'h0040 + 16'(a), 16'($urandom));
    for (int r = 0; r < 40; r++) begin
      m  = NC'($urandom_range(1, (1 << NC) - 1));
      wv = NC'($urandom);
      for (int i = 0; i < NC; i++) begin
        av[i] = {8'($urandom), 8'h40 + 8'($urandom_range(0, 15))};
        dv[i] = 16'($urandom);
      end
      round(m, wv, av, dv);
    end
  endtask

  task automatic lat3_timing();
    int n;
    @(negedge clk);
    n = cyc;
    WE[0] = 1'b0;
    ADDR[15:0] = 16'h0010;
    REQ = 2'b01;
    model_push(0, 1'b0, 16'h0010, 16'h0000, n + 1 + lat);
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      chk("lat3_busy", busy_m, (k <= 4));
      chk("lat3_gnt0", gnt_m[0], (k <= 4));
      if (k == 4) REQ[0] = 1'b0;
    end
  endtask

  task automatic lat3_reset_abort();
    one(0, 1'b1, 16'h0020, 16'hAAAA);
    @(negedge clk);
    WE[0] = 1'b1;
    ADDR[15:0]  = 16'h0020;
    WDATA[15:0] = 16'h5555;
    REQ = 2'b01;
    @(negedge clk);
    @(negedge clk);
    RST = 1'b1;
    REQ = '0;
    @(negedge clk);
    chk("abort_ack", ack_m, '0);
    chk("abort_busy", busy_m, 1'b0);
    chk("abort_gnt", gnt_m, '0);
    RST = 1'b0;
    mdl_last = NC - 1;
    mdl_rd   = '0;
    one(0, 1'b0, 16'h0020, 16'h0000);
  endtask

  initial begin
    RST = 1'b1; REQ = '0; WE = '0; ADDR = '0; WDATA = '0;
    mdl_last = NC - 1;
    mdl_rd   = '0;
    lat = 1;
    suite();
    repeat (3) @(negedge clk);
    chk("queue_drained_l1", q.size(), 0);
    do_reset();
    lat = 3;
    suite();
    lat3_timing();
    lat3_reset_abort();
    repeat (3) @(negedge clk);
    chk("queue_drained_l3", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
